// File: rtl/soc_mmio_pkg.sv
// MMIO address map and helpers shared by the SoC SRAM-port responders.
package soc_mmio_pkg;

    localparam logic [15:0] MMIO_HI_DEFAULT = 16'hbfaf;

    localparam logic [15:0] MMIO_TIMER  = 16'hE000;
    localparam logic [15:0] MMIO_LED    = 16'hF000;
    localparam logic [15:0] MMIO_SWITCH = 16'hF004;
    localparam logic [15:0] MMIO_NUM    = 16'hF010;

    // Source of the registered read data for the request just accepted.
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TIMER,
        SEL_LED,
        SEL_SWITCH,
        SEL_NUM
    } rd_sel_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  wen);
        logic [31:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (wen[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_bank.sv
// Word array with per-byte write enables and a registered read-first output.
module sram_bank #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [3:0]        i_wen,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**ADDR_W];
    logic [31:0] r_rdata;

    // Contents are never reset; a request held across reset must not land.
    always_ff @(posedge i_clk) begin
        if (i_en && i_rst_n) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (i_wen[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  r_rdata <= '0;
        else if (i_en) r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/soc_sram_responder.sv
// SRAM-port responder: on-chip RAM plus timer/LED/switch/number MMIO window.
module soc_sram_responder
    import soc_mmio_pkg::*;
#(
    parameter int unsigned ADDR_W  = 14,
    parameter logic [15:0] MMIO_HI = MMIO_HI_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic [31:0] num_out
);

    rd_sel_e     w_sel;
    logic        w_wr;
    logic        w_timer_load;
    logic [31:0] w_mmio_rdata;
    logic [31:0] w_bank_rdata;
    logic        w_unused_addr;

    rd_sel_e     r_sel;
    logic [31:0] r_mmio_rdata;
    logic [31:0] r_timer;
    logic [15:0] r_led;
    logic [31:0] r_num;
    logic [7:0]  r_sw_meta;
    logic [7:0]  r_sw_sync;

    assign w_unused_addr = ^sram_addr[1:0];

    always_comb begin
        w_sel = SEL_RAM;
        if (sram_addr[31:16] == MMIO_HI) begin
            case (sram_addr[15:0])
                MMIO_TIMER:  w_sel = SEL_TIMER;
                MMIO_LED:    w_sel = SEL_LED;
                MMIO_SWITCH: w_sel = SEL_SWITCH;
                MMIO_NUM:    w_sel = SEL_NUM;
                default:     w_sel = SEL_NONE;
            endcase
        end
    end

    assign w_wr         = sram_en && (sram_wen != '0);
    assign w_timer_load = sram_en && (w_sel == SEL_TIMER) && (sram_wen == 4'hF);

    always_comb begin
        w_mmio_rdata = '0;
        case (w_sel)
            SEL_TIMER:  w_mmio_rdata = r_timer;
            SEL_LED:    w_mmio_rdata = {16'h0000, r_led};
            SEL_SWITCH: w_mmio_rdata = {24'h000000, r_sw_sync};
            SEL_NUM:    w_mmio_rdata = r_num;
            default:    w_mmio_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sel        <= SEL_NONE;
            r_mmio_rdata <= '0;
            r_timer      <= '0;
            r_led        <= '0;
            r_num        <= '0;
            r_sw_meta    <= '0;
            r_sw_sync    <= '0;
        end else begin
            r_sw_meta <= switch_in;
            r_sw_sync <= r_sw_meta;
            r_timer   <= w_timer_load ? sram_wdata : r_timer + 32'd1;
            if (sram_en) begin
                r_sel        <= w_sel;
                r_mmio_rdata <= w_mmio_rdata;
            end
            if (w_wr && (w_sel == SEL_LED)) begin
                r_led <= {sram_wen[1] ? sram_wdata[15:8] : r_led[15:8],
                          sram_wen[0] ? sram_wdata[7:0]  : r_led[7:0]};
            end
            if (w_wr && (w_sel == SEL_NUM)) r_num <= byte_merge(r_num, sram_wdata, sram_wen);
        end
    end

    sram_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .i_clk   (clk),
        .i_rst_n (resetn),
        .i_en    (sram_en && (w_sel == SEL_RAM)),
        .i_wen   (sram_wen),
        .i_addr  (sram_addr[ADDR_W+1:2]),
        .i_wdata (sram_wdata),
        .o_rdata (w_bank_rdata)
    );

    // The bank holds its last RAM word across MMIO reads, so pick by the registered select.
    assign sram_rdata = (r_sel == SEL_RAM) ? w_bank_rdata : r_mmio_rdata;
    assign led_out    = r_led;
    assign num_out    = r_num;

endmodule

// File: doc/soc_sram_responder.md
# soc_sram_responder

Responder side of the core's SRAM-style memory port (en / 4-bit byte write-enable / 32-bit addr / wdata / rdata with fixed one-cycle read latency). It serves either fetch or data traffic from an on-chip word array, and decodes a small MMIO window holding a free-running timer, LED, number and switch registers. One instance sits on each of the core's inst and data ports in the simulation/FPGA SoC top.

## Interface
- `ADDR_W`, default 14: word-index bits of the RAM array (2^ADDR_W words).
- `MMIO_HI`, default 16'hbfaf: value of `sram_addr[31:16]` that selects the MMIO window.
- `clk` in 1: single clock, all state on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `sram_en` in 1: request valid this cycle.
- `sram_wen` in 4: byte write enables; 0 = read.
- `sram_addr` in 32: byte address; bits [1:0] ignored.
- `sram_wdata` in 32: write data, byte lane i = bits [8i+7:8i].
- `sram_rdata` out 32: read data, registered.
- `switch_in` in 8: asynchronous board switches.
- `led_out` out 16: LED register.
- `num_out` out 32: number-display register.

## Operation
- Decode: MMIO when `sram_addr[31:16]==MMIO_HI`, else RAM at word index `sram_addr[ADDR_W+1:2]`. Upper RAM address bits are ignored, so the array aliases.
- RAM write (en, wen!=0): each lane with `wen[i]=1` updates at the clock edge. Other lanes are kept.
- RAM read: every cycle with en=1, `sram_rdata` is loaded with the word at the index. The read is read-first: a write cycle returns the pre-write word.
- RAM contents are not reset.
- MMIO offsets are `sram_addr[15:0]`:
  - 16'hE000 TIMER: 32-bit counter, +1 every cycle, wraps FFFF_FFFF→0. A write with wen==4'hF loads wdata, and counting resumes from it the next cycle. Partial writes are ignored.
  - 16'hF000 LED: RW, bits [15:0], byte-enable merge. Upper wdata bits are ignored. Reads zero-extend.
  - 16'hF004 SWITCH: RO, returns the 2-flop-synchronized switch value zero-extended. Writes are ignored.
  - 16'hF010 NUM: RW, 32-bit, byte-enable merge.
  - Any other offset reads 0, and writes are ignored.
- MMIO reads are read-first, same as RAM. A TIMER read returns the count present in the request cycle.
- en=0: `sram_rdata`, RAM and MMIO registers hold, except TIMER (always counts) and the switch synchronizer (always samples).

## Timing
- Read latency is exactly 1 cycle: a request at edge N gives valid rdata after edge N, and rdata holds until the next en=1 edge.
- Back-to-back requests are accepted every cycle. There is no stall or backpressure.
- Write effects are visible to a read issued the following cycle.
- `led_out`/`num_out` change after the write edge. A switch change is visible to reads 2 cycles later.
- Reset (async assert, any time including mid-burst):
  - `sram_rdata`=0, LED=0, NUM=0, TIMER=0, sync flops=0.
  - A request coincident with reset is dropped.
  - TIMER reads 0 in the first cycle after deassert, then increments.
  - RAM contents are untouched.

## Structure
- A shared package `soc_mmio_pkg` holds the MMIO offset localparams (TIMER/LED/SWITCH/NUM) and the default `MMIO_HI`.
- Sub-module `sram_bank`: parameterized ADDR_W x 32 array with per-byte write enables and a registered read-first output. It is the only sub-module. The decode, MMIO registers and rdata mux stay in the top.

## Test plan
- Full write: write 32'h1234_5678 to 0x0000_0010 with wen=F, then read the same address → rdata 32'h1234_5678 one cycle after the read.
- Byte lanes: after the full write above, write wen=4'b0100 with wdata=32'h00AB_0000, then read → 32'h12AB_5678. The write cycle itself returns 32'h1234_5678 (read-first).
- Aliasing: read `(1<<(ADDR_W+2))+0x10` → same word as 0x10.
- Timer:
  - After reset deassert, read 0xbfaf_E000 at cycle k → rdata=k.
  - Write FFFF_FFFE (wen=F), then read 2 cycles later → FFFF_FFFF (write edge loads FFFF_FFFE, +1 next cycle, read samples that value).
  - A further read 1 cycle after → 0 (wrap).
- LED/NUM/SWITCH:
  - Write 0xbfaf_F000 with wen=4'b0001, wdata=FFFF_FFA5 → `led_out`=16'h00A5.
  - Write 0xbfaf_F010 with wen=F, wdata=DEAD_BEEF → `num_out`=DEAD_BEEF.
  - Set `switch_in`=8'h3C, then read F004 3+ cycles later → 32'h0000_003C.
  - Read 0xbfaf_F008 → 0.
- Async reset mid-burst:
  - Drop resetn between clock edges during reads → `sram_rdata`, `led_out`, `num_out` go 0 immediately.
  - After release, the RAM word at 0x10 still reads 32'h12AB_5678.
